// File: rtl/cart_save_backup.sv
// Moves the cartridge save RAM to and from the SD save image one 512-byte sector at a time.
// A nonzero image mount loads the image into cart RAM; bk_save writes cart RAM back to the image.
module cart_save_backup #(
    parameter int SECTOR_WORDS = 256,
    parameter int LBA_W        = 8
) (
    input  logic                                  clk_sys,
    input  logic                                  reset_n,
    input  logic                                  has_save,
    input  logic [LBA_W-1:0]                      ram_mask_file,
    input  logic                                  cart_download,
    input  logic                                  img_mounted,
    input  logic                                  img_readonly,
    input  logic [63:0]                           img_size,
    input  logic                                  bk_save,
    output logic [31:0]                           sd_lba,
    output logic                                  sd_rd,
    output logic                                  sd_wr,
    input  logic                                  sd_ack,
    input  logic [$clog2(SECTOR_WORDS)-1:0]       sd_buff_addr,
    input  logic [15:0]                           sd_buff_dout,
    input  logic                                  sd_buff_wr,
    output logic [15:0]                           sd_buff_din,
    output logic                                  bk_wr,
    output logic [LBA_W+$clog2(SECTOR_WORDS):0]   bk_addr,
    output logic [15:0]                           bk_data,
    input  logic [15:0]                           bk_q,
    output logic                                  bk_busy,
    output logic                                  bk_loading,
    output logic                                  bk_done
);
    typedef enum logic [1:0] {IDLE, REQ, XFER, NEXT} state_e;

    state_e           state_q, state_d;
    logic [LBA_W-1:0] lba_q, lba_d;
    logic [LBA_W-1:0] mask_q, mask_d;
    logic             loading_q, loading_d;
    logic             img_present_q, img_present_d;
    logic             save_pending_q, save_pending_d;
    logic             ack_q, ack_d;
    logic             download_q, download_d;

    logic             load_start, save_start, last_sector, download_rise;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            lba_q          <= '0;
            mask_q         <= '0;
            loading_q      <= 1'b0;
            img_present_q  <= 1'b0;
            save_pending_q <= 1'b0;
            ack_q          <= 1'b0;
            download_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            lba_q          <= lba_d;
            mask_q         <= mask_d;
            loading_q      <= loading_d;
            img_present_q  <= img_present_d;
            save_pending_q <= save_pending_d;
            ack_q          <= ack_d;
            download_q     <= download_d;
        end
    end

    // Load wins over a pending save when both are ready in the same IDLE cycle.
    always_comb begin
        download_rise = cart_download && !download_q;
        load_start    = (state_q == IDLE) && img_mounted && (img_size != '0) && has_save && !cart_download;
        save_start    = (state_q == IDLE) && !load_start && save_pending_q && img_present_q && has_save
                        && !img_readonly && !cart_download;
        last_sector   = (lba_q == mask_q);
    end

    // NOTE: every signal gets a default at the top of the block so no latch is inferred.
    always_comb begin
        state_d        = state_q;
        lba_d          = lba_q;
        mask_d         = mask_q;
        loading_d      = loading_q;
        img_present_d  = img_present_q;
        save_pending_d = save_pending_q;
        ack_d          = sd_ack;
        download_d     = cart_download;

        if (img_mounted)   img_present_d  = (img_size != '0);
        if (bk_save)       save_pending_d = 1'b1;
        // A save request arriving as its save starts merges into that save.
        if (save_start)    save_pending_d = 1'b0;
        if (download_rise) begin
            img_present_d  = 1'b0;
            save_pending_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (load_start || save_start) begin
                    state_d   = REQ;
                    lba_d     = '0;
                    mask_d    = ram_mask_file;
                    loading_d = load_start;
                end
            end
            REQ:  if (sd_ack) state_d = XFER;
            XFER: if (ack_q && !sd_ack) state_d = NEXT;
            NEXT: begin
                if (last_sector) begin
                    state_d   = IDLE;
                    loading_d = 1'b0;
                end else begin
                    state_d = REQ;
                    lba_d   = lba_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath buses are held at zero while idle so reset and spurious acks leave them quiet.
    always_comb begin
        bk_busy     = (state_q != IDLE);
        bk_loading  = loading_q;
        bk_done     = (state_q == NEXT) && last_sector;
        sd_rd       = (state_q == REQ) && loading_q;
        sd_wr       = (state_q == REQ) && !loading_q;
        sd_lba      = 32'(lba_q);
        bk_addr     = '0;
        bk_data     = '0;
        sd_buff_din = '0;
        bk_wr       = sd_buff_wr && sd_ack && loading_q;
        if (bk_busy) begin
            bk_addr = {1'b0, lba_q, sd_buff_addr};
            if (loading_q) bk_data     = sd_buff_dout;
            else           sd_buff_din = bk_q;
        end
    end
endmodule

// File: tb/tb_cart_save_backup.sv
// Directed/random bench for cart_save_backup: emulates the SD sector block and cart RAM and
// checks loads and saves against an image-level reference of what cart RAM and the SD image should hold.
module tb_cart_save_backup;
    localparam int SW = 256;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        has_save;
    logic [7:0]  ram_mask_file;
    logic        cart_download;
    logic        img_mounted;
    logic        img_readonly;
    logic [63:0] img_size;
    logic        bk_save;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout;
    logic        sd_buff_wr;
    logic [15:0] sd_buff_din;
    logic        bk_wr;
    logic [16:0] bk_addr;
    logic [15:0] bk_data;
    logic [15:0] bk_q;
    logic        bk_busy;
    logic        bk_loading;
    logic        bk_done;

    cart_save_backup dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .has_save(has_save), .ram_mask_file(ram_mask_file),
        .cart_download(cart_download), .img_mounted(img_mounted), .img_readonly(img_readonly),
        .img_size(img_size), .bk_save(bk_save), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .bk_wr(bk_wr), .bk_addr(bk_addr),
        .bk_data(bk_data), .bk_q(bk_q), .bk_busy(bk_busy), .bk_loading(bk_loading), .bk_done(bk_done)
    );

    always #5 clk_sys = ~clk_sys;

    // Cart save RAM with one cycle read latency, plus write/done event counters.
    logic [15:0] cart_mem [0:131071];
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    always @(posedge clk_sys) begin
        if (bk_wr) begin
            cart_mem[bk_addr] <= bk_data;
            wr_cnt            <= wr_cnt + 1;
        end
        if (bk_done) done_cnt <= done_cnt + 1;
        bk_q <= cart_mem[bk_addr];
    end

    logic [15:0] sd_img  [0:16*SW-1];
    logic [15:0] ram_ref [0:16*SW-1];
    logic [8:0]  req_q [$];
    int          tests = 0;
    int          fails = 0;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the falling edge.
    task automatic tick();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic pulse_mount(input logic [63:0] size);
        img_size    = size;
        img_mounted = 1'b1;
        tick();
        img_mounted = 1'b0;
    endtask

    task automatic pulse_save();
        bk_save = 1'b1;
        tick();
        bk_save = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_sd_rd"},      sd_rd, 0);
        check({pfx, "_sd_wr"},      sd_wr, 0);
        check({pfx, "_bk_busy"},    bk_busy, 0);
        check({pfx, "_bk_loading"}, bk_loading, 0);
        check({pfx, "_bk_done"},    bk_done, 0);
        check({pfx, "_bk_wr"},      bk_wr, 0);
        check({pfx, "_sd_lba"},     sd_lba, 0);
        check({pfx, "_bk_addr"},    bk_addr, 0);
        check({pfx, "_bk_data"},    bk_data, 0);
        check({pfx, "_sd_buff_din"}, sd_buff_din, 0);
    endtask

    // Plays the SD block for one sector: reads stream image words, writes capture sd_buff_din
    // one cycle after presenting each word address.
    task automatic serve_sector(input int sec, input logic [15:0] save_secs, input int rst_sec,
                                output bit aborted);
        logic rd;
        int   l;
        aborted = 1'b0;
        rd      = sd_rd;
        l       = int'(sd_lba);
        req_q.push_back({rd, sd_lba[7:0]});
        sd_ack  = 1'b1;
        for (int a = 0; a <= SW; a++) begin
            if (rd) begin
                if (a == SW) break;
                sd_buff_addr = 8'(a);
                sd_buff_dout = sd_img[l*SW + a];
                sd_buff_wr   = 1'b1;
            end else begin
                if (a > 0) sd_img[l*SW + a - 1] = sd_buff_din;
                if (a == SW) break;
                sd_buff_addr = 8'(a);
            end
            bk_save = save_secs[sec] && (a == 10);
            if (sec == rst_sec && a == 50) begin
                reset_n = 1'b0;
                #1;
                check_reset_outputs("midxfer_rst");
                aborted = 1'b1;
                break;
            end
            tick();
        end
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        bk_save    = 1'b0;
        tick();
    endtask

    // Services requests until one bk_done is seen, the budget runs out, or a planned reset aborts.
    task automatic serve(input string tag, input int budget, input logic [15:0] save_secs, input int rst_sec);
        int start_done = done_cnt;
        int sec        = 0;
        int n          = 0;
        bit ab;
        req_q.delete();
        while (done_cnt == start_done && n < budget) begin
            if (sd_rd || sd_wr) begin
                serve_sector(sec, save_secs, rst_sec, ab);
                sec++;
                n += SW + 2;
                if (ab) return;
            end else begin
                tick();
                n++;
            end
        end
        check({tag, "_done_in_budget"}, done_cnt - start_done, 1);
    endtask

    task automatic check_reqs(input string tag, input logic rd, input int n);
        int bad = 0;
        check({tag, "_req_count"}, req_q.size(), n);
        foreach (req_q[i]) if (req_q[i] !== {rd, 8'(i)}) bad++;
        check({tag, "_req_seq_bad"}, bad, 0);
    endtask

    task automatic model_load(input int mask);
        for (int i = 0; i < (mask + 1) * SW; i++) ram_ref[i] = sd_img[i];
    endtask

    task automatic check_ram(input string tag);
        int bad = 0;
        for (int i = 0; i < 16*SW; i++) if (cart_mem[i] !== ram_ref[i]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic idle_window(input string tag, input int n);
        int act = 0;
        repeat (n) begin
            tick();
            if (sd_rd || sd_wr || bk_busy) act++;
        end
        check(tag, act, 0);
    endtask

    initial begin
        int w0, d0, m, bad;
        reset_n = 1'b0; has_save = 1'b0; ram_mask_file = '0; cart_download = 1'b0;
        img_mounted = 1'b0; img_readonly = 1'b0; img_size = '0; bk_save = 1'b0;
        sd_ack = 1'b1; sd_buff_addr = 8'h33; sd_buff_dout = 16'hBEEF; sd_buff_wr = 1'b1;

        // Reset state with the SD side deliberately busy.
        repeat (3) tick();
        check_reset_outputs("reset");
        sd_ack = 1'b0; sd_buff_wr = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0;
        tick();
        reset_n = 1'b1;
        repeat (2) tick();

        // Full 16-sector load.
        for (int i = 0; i < 16*SW; i++) sd_img[i] = 16'($urandom);
        sd_img[3*SW + 5] = 16'h1234;
        has_save = 1'b1; ram_mask_file = 8'h0F;
        w0 = wr_cnt; d0 = done_cnt;
        pulse_mount(64'd8192);
        check("load_start_busy", bk_busy, 1);
        check("load_start_loading", bk_loading, 1);
        check("load_start_sd_rd", sd_rd, 1);
        serve("load16", 6000, '0, -1);
        model_load(15);
        check_reqs("load16", 1'b1, 16);
        check("load16_word_0305", cart_mem[17'h0305], 16'h1234);
        check_ram("load16_ram_image");
        check("load16_wr_count", wr_cnt - w0, 16*SW);
        idle_window("load16_idle_after", 5);
        check("load16_one_done", done_cnt - d0, 1);
        check("load16_loading_low", bk_loading, 0);

        // Four-sector save back to a cleared image.
        for (int i = 0; i < 5*SW; i++) sd_img[i] = '0;
        ram_mask_file = 8'h03;
        w0 = wr_cnt;
        pulse_save();
        serve("save4", 2000, '0, -1);
        check_reqs("save4", 1'b0, 4);
        bad = 0;
        for (int i = 0; i < 4*SW; i++) if (sd_img[i] !== ram_ref[i]) bad++;
        check("save4_image_match", bad, 0);
        bad = 0;
        for (int i = 4*SW; i < 5*SW; i++) if (sd_img[i] !== 16'h0) bad++;
        check("save4_sector4_untouched", bad, 0);
        check("save4_no_bk_wr", wr_cnt - w0, 0);

        // Random-size load with two save pulses during it: exactly one save follows.
        for (int i = 0; i < 16*SW; i++) sd_img[i] = 16'($urandom);
        m = int'($urandom_range(3, 7));
        ram_mask_file = 8'(m);
        pulse_mount(64'd8192);
        serve("loadm", 4000, 16'h0006, -1);
        model_load(m);
        check_reqs("loadm", 1'b1, m + 1);
        check_ram("loadm_ram_image");
        tick();
        check("save_after_load_sd_wr", sd_wr, 1);
        check("save_after_load_lba", sd_lba, 0);
        serve("merged_save", 4000, '0, -1);
        check_reqs("merged_save", 1'b0, m + 1);
        idle_window("merged_single_save", 30);

        // Spurious ack while idle.
        w0 = wr_cnt;
        sd_ack = 1'b1; sd_buff_wr = 1'b1; sd_buff_dout = 16'($urandom);
        idle_window("spurious_ack_idle", 5);
        sd_ack = 1'b0; sd_buff_wr = 1'b0;
        tick();
        check("spurious_ack_no_wr", wr_cnt - w0, 0);

        // Empty image: no load, and a save request stays pending without starting.
        pulse_mount(64'd0);
        pulse_save();
        idle_window("empty_image_no_xfer", 20);

        // Nonzero remount loads, then the still-pending save runs.
        ram_mask_file = 8'h00;
        pulse_mount(64'd512);
        serve("remount_load", 1000, '0, -1);
        check_reqs("remount_load", 1'b1, 1);
        tick();
        check("pending_save_after_remount", sd_wr, 1);
        serve("pending_save", 1000, '0, -1);
        check_reqs("pending_save", 1'b0, 1);

        // Read-only image, then cart_download clearing the mount.
        img_readonly = 1'b1;
        pulse_save();
        idle_window("readonly_no_save", 20);
        cart_download = 1'b1;
        tick();
        cart_download = 1'b0; img_readonly = 1'b0;
        pulse_save();
        idle_window("download_clears_mount", 20);

        // No battery RAM: mount neither loads nor allows saves.
        has_save = 1'b0;
        pulse_mount(64'd8192);
        pulse_save();
        idle_window("no_has_save", 20);

        // Reset in the middle of sector 2 of a load.
        has_save = 1'b1; ram_mask_file = 8'h0F;
        pulse_mount(64'd8192);
        serve("rst_load", 6000, '0, 2);
        check_reqs("rst_load", 1'b1, 3);
        w0 = wr_cnt;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        pulse_save();
        idle_window("post_reset_save_ignored", 30);
        check("post_reset_no_wr", wr_cnt - w0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cart_save_backup.md
Name: cart_save_backup

Overview:
- Sequencer between the SD-card sector interface and the cartridge save-RAM backup port (bk_*) of the cart block.
- On image mount it loads the .sav image sector by sector into cart RAM.
- On a save request it streams cart RAM back to the SD image.
- Sector count follows the cart's ram_mask_file, so only the populated save area moves.

Parameters:
- SECTOR_WORDS, 256, 16-bit words per 512-byte SD sector; fixes the sd_buff_addr width at 8.
- LBA_W, 8, width of the internal sector counter; max 256 sectors = 128 KB.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- has_save  in  1  cart has battery-backed RAM
- ram_mask_file  in  8  last sector index of the save image
- cart_download  in  1  ROM download in progress
- img_mounted  in  1  one-cycle pulse: SD image (re)mounted
- img_readonly  in  1  mounted image is write-protected
- img_size  in  64  mounted image size in bytes
- bk_save  in  1  one-cycle pulse: save requested
- sd_lba  out  32  sector address to SD block
- sd_rd  out  1  sector read request
- sd_wr  out  1  sector write request
- sd_ack  in  1  SD block owns the buffer; high for the whole sector transfer
- sd_buff_addr  in  8  word index inside the sector
- sd_buff_dout  in  16  word read from the SD image
- sd_buff_wr  in  1  sd_buff_dout valid this cycle
- sd_buff_din  out  16  word to write to the SD image
- bk_wr  out  1  cart RAM write strobe
- bk_addr  out  17  cart RAM word address
- bk_data  out  16  cart RAM write data
- bk_q  in  16  cart RAM read data; 1-cycle RAM latency
- bk_busy  out  1  transfer in progress
- bk_loading  out  1  current transfer is a load
- bk_done  out  1  one-cycle pulse at transfer completion

Behaviour:
- Reset: all outputs 0; state IDLE; img_present 0; save_pending 0; lba 0.
- img_mounted pulse:
  - img_present <= (img_size != 0).
  - Load starts from IDLE only if img_size != 0 && has_save && !cart_download.
- bk_save pulse:
  - Sets save_pending.
  - A save starts from IDLE when save_pending && img_present && has_save && !img_readonly && !cart_download; save_pending clears on start.
  - bk_save while busy stays pending, one deep; repeats merge.
- Same-cycle img_mounted and bk_save in IDLE: load starts, save stays pending.
- cart_download rising edge: clears img_present and save_pending. It does not abort an active transfer.
- State machine:
  - IDLE -> REQ: lba <= 0; bk_busy = 1; bk_loading = (load).
  - REQ: sd_rd (load) or sd_wr (save) = 1; sd_lba = {24'b0, lba}. On sd_ack = 1, drop the request next cycle -> XFER.
  - XFER: wait for sd_ack falling edge -> NEXT.
  - NEXT: if lba == ram_mask_file, go to IDLE, pulse bk_done, clear bk_busy/bk_loading. Otherwise lba <= lba + 1 -> REQ.
- Per-sector datapath, all combinational from the SD side:
  - bk_addr = {1'b0, lba, sd_buff_addr}.
  - bk_data = sd_buff_dout.
  - bk_wr = sd_buff_wr && sd_ack && bk_loading.
  - sd_buff_din = bk_q. The SD block presents sd_buff_addr one cycle before it samples the data, which covers the RAM latency.
  - Never bk_wr during a save.
- Sector count = ram_mask_file + 1. ram_mask_file is sampled at transfer start and held until done. lba never exceeds the sampled mask; no wrap.
- sd_ack high while in IDLE (spurious): ignored, no bk_wr.
- Reset mid-transfer: immediate return to IDLE. sd_rd/sd_wr drop; pending and img_present clear.

Test Plan:
- Reset, then img_mounted with img_size = 8192, has_save = 1, ram_mask_file = 0x0F -> 16 read requests, sd_lba 0..15. Word 0x1234 at buff_addr 5 of sector 3 -> bk_wr with bk_addr 0x0305, bk_data 0x1234. One bk_done; bk_busy low afterwards.
- After the mount, bk_save with ram_mask_file = 0x03 -> 4 write requests, lba 0..3. sd_buff_din follows bk_q; bk_wr never asserts.
- bk_save pulsed during an active load -> save starts in the cycle after load bk_done. Two pulses during the load -> only one save.
- img_mounted with img_size = 0, then bk_save -> no sd_rd/sd_wr; bk_busy stays 0.
- img_readonly = 1 or has_save = 0, then bk_save -> no transfer. cart_download rising -> subsequent bk_save ignored until the next nonzero mount.
- reset_n low in the middle of sector 2 of a load -> outputs 0 in the same cycle; no bk_wr afterwards; after release, bk_save is ignored until the next mount.
